// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcode/condition codes, FSM states and flag helpers for seq_alu (SEQ_ALU_MUL_EN adds the MUL state)
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MOVI = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd11;
    localparam logic [3:0] OP_LDR  = 4'd13;
    localparam logic [3:0] OP_NOP  = 4'd15;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_GT = 4'd2;
    localparam logic [3:0] COND_LT = 4'd3;
    localparam logic [3:0] COND_GE = 4'd4;
    localparam logic [3:0] COND_LE = 4'd5;
    localparam logic [3:0] COND_HI = 4'd6;
    localparam logic [3:0] COND_LO = 4'd7;
    localparam logic [3:0] COND_HS = 4'd8;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [2:0] SR_LSR = 3'd1;
    localparam logic [2:0] SR_LSL = 3'd2;
    localparam logic [2:0] SR_ROR = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef SEQ_ALU_MUL_EN
        ST_MUL  = 2'd1,
`endif
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cond)
            COND_AL: cond_pass = 1'b1;
            COND_EQ: cond_pass = z;
            COND_GT: cond_pass = !z && (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GE: cond_pass = (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_HI: cond_pass = c && !z;
            COND_LO: cond_pass = !c;
            COND_HS: cond_pass = c;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/result handshake bundle for seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    import seq_alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [3:0]       cond;
    logic             s;
    logic [2:0]       sr_cont;
    logic [SHW-1:0]   sr_bit;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [15:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cond_met;
    logic [3:0]       flags;

    modport master (
        output in_valid, opcode, cond, s, sr_cont, sr_bit, in1, in2, imm, out_ready,
        input  in_ready, out_valid, result, cond_met, flags
    );

    modport slave (
        input  in_valid, opcode, cond, s, sr_cont, sr_bit, in1, in2, imm, out_ready,
        output in_ready, out_valid, result, cond_met, flags
    );

endinterface

// File: rtl/seq_alu_mul.sv
// rtl/seq_alu_mul.sv - iterative shift-add multiplier, one partial product per cycle
module seq_alu_mul #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done
);
    logic [WIDTH-1:0] acc, mcand, mplier, acc_next;
    logic [SHW-1:0]   cnt;
    logic             busy;

    // product is presented combinationally so the last iteration's sum is usable on the done edge
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = busy && (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - conditional ALU with pre-shifter and result hold; SEQ_ALU_MUL_EN enables iterative MUL
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam int M = WIDTH - 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] result_q, sh2, alu_res, fsrc;
    logic [2*WIDTH-1:0] rot;
    logic [WIDTH+15:0]  imm_ext;
    logic [WIDTH:0]   add_w, sub_w;
    logic [3:0]       flags_q, alu_flags;
    logic             cond_q, accept, met, upd_ok, c_f, v_f;

    assign accept        = bus.in_valid && bus.in_ready;
    assign met           = cond_pass(bus.cond, flags_q);
    assign bus.in_ready  = (state == ST_IDLE) && !rst;
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.result    = result_q;
    assign bus.cond_met  = cond_q;
    assign bus.flags     = flags_q;

    assign rot     = {bus.in2, bus.in2} >> bus.sr_bit;
    assign imm_ext = {{WIDTH{1'b0}}, bus.imm};
    assign add_w   = {1'b0, bus.in1} + {1'b0, sh2};
    assign sub_w   = {1'b0, bus.in1} - {1'b0, sh2};

    always_comb begin
        case (bus.sr_cont)
            SR_LSR:  sh2 = bus.in2 >> bus.sr_bit;
            SR_LSL:  sh2 = bus.in2 << bus.sr_bit;
            SR_ROR:  sh2 = rot[WIDTH-1:0];
            default: sh2 = bus.in2;
        endcase
    end

    always_comb begin
        alu_res = bus.in1;
        c_f     = 1'b0;
        v_f     = 1'b0;
        upd_ok  = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                c_f     = add_w[WIDTH];
                v_f     = (bus.in1[M] == sh2[M]) && (add_w[M] != bus.in1[M]);
                upd_ok  = bus.s;
            end
            OP_SUB, OP_CMP: begin
                alu_res = (bus.opcode == OP_CMP) ? '0 : sub_w[WIDTH-1:0];
                c_f     = !sub_w[WIDTH];
                v_f     = (bus.in1[M] != sh2[M]) && (sub_w[M] != bus.in1[M]);
                upd_ok  = bus.s || (bus.opcode == OP_CMP);
            end
            OP_OR:   begin alu_res = bus.in1 | sh2; upd_ok = bus.s; end
            OP_AND:  begin alu_res = bus.in1 & sh2; upd_ok = bus.s; end
            OP_XOR:  begin alu_res = bus.in1 ^ sh2; upd_ok = bus.s; end
            OP_MOVI: alu_res = imm_ext[WIDTH-1:0];
            // MUL flags are written on completion when the multiplier is built in
            OP_MUL, OP_NOP: alu_res = '0;
            default: alu_res = bus.in1;
        endcase
        fsrc      = (bus.opcode == OP_CMP) ? sub_w[WIDTH-1:0] : alu_res;
        alu_flags = {fsrc[M], (fsrc == '0), c_f, v_f};
    end

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] mul_product;
    logic             mul_done, mul_start, mul_upd;

    assign mul_start = accept && (bus.opcode == OP_MUL) && met;

    seq_alu_mul #(.WIDTH(WIDTH), .SHW(SHW)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.in1),
        .b       (sh2),
        .product (mul_product),
        .done    (mul_done)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_next = ST_HOLD;
`ifdef SEQ_ALU_MUL_EN
                if (mul_start)
                    state_next = ST_MUL;
`endif
            end
`ifdef SEQ_ALU_MUL_EN
            ST_MUL:  if (mul_done) state_next = ST_HOLD;
`endif
            ST_HOLD: if (bus.out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            cond_q   <= 1'b0;
            flags_q  <= 4'b0000;
`ifdef SEQ_ALU_MUL_EN
            mul_upd  <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE && accept) begin
                result_q <= met ? alu_res : '0;
                cond_q   <= met;
                if (met && upd_ok)
                    flags_q <= alu_flags;
`ifdef SEQ_ALU_MUL_EN
                mul_upd  <= bus.s;
`endif
            end
`ifdef SEQ_ALU_MUL_EN
            if (state == ST_MUL && mul_done) begin
                result_q <= mul_product;
                cond_q   <= 1'b1;
                if (mul_upd)
                    flags_q <= {mul_product[M], (mul_product == '0), 2'b00};
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (MUL checks follow SEQ_ALU_MUL_EN)
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    int   cyc;
    logic ready_seen;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] cd, input logic sv,
                        input logic [2:0] sc, input logic [4:0] sb,
                        input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        bus.opcode   = op;
        bus.cond     = cd;
        bus.s        = sv;
        bus.sr_cont  = sc;
        bus.sr_bit   = sb;
        bus.in1      = a;
        bus.in2      = b;
        bus.imm      = im;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.opcode = OP_NOP; bus.cond = COND_AL; bus.s = 1'b0;
        bus.sr_cont = 3'd0; bus.sr_bit = 5'd0;
        bus.in1 = '0; bus.in2 = '0; bus.imm = '0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_cond_met", 32'(bus.cond_met), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        send(OP_ADD, COND_AL, 1'b1, 3'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, 16'h0);
        check("add_ov_latency", 32'(bus.out_valid), 32'd1);
        check("add_ov_result", bus.result, 32'h8000_0000);
        check("add_ov_flags", 32'(bus.flags), 32'b1001);
        check("add_ov_cond", 32'(bus.cond_met), 32'd1);
        consume();

        send(OP_ADD, COND_AL, 1'b1, 3'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0);
        check("add_carry_result", bus.result, 32'd0);
        check("add_carry_flags", 32'(bus.flags), 32'b0110);
        consume();

        send(OP_CMP, COND_AL, 1'b0, 3'd0, 5'd0, 32'd5, 32'd5, 16'h0);
        check("cmp_result", bus.result, 32'd0);
        check("cmp_flags", 32'(bus.flags), 32'b0110);
        consume();

        send(OP_SUB, COND_EQ, 1'b0, 3'd0, 5'd0, 32'd10, 32'd3, 16'h0);
        check("sub_eq_result", bus.result, 32'd7);
        check("sub_eq_cond", 32'(bus.cond_met), 32'd1);
        consume();

        send(OP_SUB, COND_GT, 1'b1, 3'd0, 5'd0, 32'd10, 32'd3, 16'h0);
        check("sub_gt_valid", 32'(bus.out_valid), 32'd1);
        check("sub_gt_result", bus.result, 32'd0);
        check("sub_gt_cond", 32'(bus.cond_met), 32'd0);
        check("sub_gt_flags", 32'(bus.flags), 32'b0110);
        consume();

        send(OP_OR, COND_AL, 1'b0, SR_ROR, 5'd1, 32'd0, 32'h8000_0001, 16'h0);
        check("or_ror_result", bus.result, 32'hC000_0000);
        consume();

        send(OP_ADD, COND_AL, 1'b0, SR_LSL, 5'd4, 32'd1, 32'h0F, 16'h0);
        check("add_lsl_result", bus.result, 32'hF1);
        consume();

        send(OP_SUB, COND_AL, 1'b1, SR_LSR, 5'd4, 32'd0, 32'h100, 16'h0);
        check("sub_lsr_result", bus.result, 32'hFFFF_FFF0);
        check("sub_lsr_flags", 32'(bus.flags), 32'b1000);
        consume();

        send(OP_MOVI, COND_AL, 1'b1, 3'd0, 5'd0, 32'h1234, 32'h0, 16'hBEEF);
        check("movi_result", bus.result, 32'h0000_BEEF);
        check("movi_flags", 32'(bus.flags), 32'b1000);
        consume();

        send(OP_XOR, COND_AL, 1'b1, 3'd0, 5'd0, 32'hFF00_FF00, 32'hFF00_FF00, 16'h0);
        check("xor_result", bus.result, 32'd0);
        check("xor_flags", 32'(bus.flags), 32'b0100);
        consume();

        send(OP_MOV, 4'd9, 1'b0, 3'd0, 5'd0, 32'h1234, 32'h0, 16'h0);
        check("never_result", bus.result, 32'd0);
        check("never_cond", 32'(bus.cond_met), 32'd0);
        consume();

        send(OP_AND, COND_AL, 1'b0, 3'd0, 5'd0, 32'hF0F0, 32'hFF, 16'h0);
        for (int i = 0; i < 3; i++) begin
            check("hold_result", bus.result, 32'hF0);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            if (i < 2) @(negedge clk);
        end
        consume();
        check("hold_release_ready", 32'(bus.in_ready), 32'd1);
        check("hold_release_valid", 32'(bus.out_valid), 32'd0);

`ifdef SEQ_ALU_MUL_EN
        send(OP_MUL, COND_AL, 1'b1, 3'd0, 5'd0, 32'h0000_FFFF, 32'h0001_0001, 16'h0);
        cyc = 1;
        ready_seen = 1'b0;
        while (!bus.out_valid && cyc < 100) begin
            if (bus.in_ready) ready_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("mul_latency", 32'(cyc), 32'd33);
        check("mul_in_ready_low", 32'(ready_seen), 32'd0);
        check("mul_result", bus.result, 32'hFFFF_FFFF);
        check("mul_flags", 32'(bus.flags), 32'b1000);
        consume();

        send(OP_MUL, COND_AL, 1'b1, 3'd0, 5'd0, 32'd3, 32'd5, 16'h0);
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mulrst_valid", 32'(bus.out_valid), 32'd0);
        check("mulrst_flags", 32'(bus.flags), 32'h0);
        check("mulrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mulrst_ready_after", 32'(bus.in_ready), 32'd1);
        ready_seen = 1'b0;
        repeat (40) begin
            if (bus.out_valid) ready_seen = 1'b1;
            @(negedge clk);
        end
        check("mulrst_discarded", 32'(ready_seen), 32'd0);
`else
        send(OP_MUL, COND_AL, 1'b1, 3'd0, 5'd0, 32'h0000_FFFF, 32'h0001_0001, 16'h0);
        check("mulnop_latency", 32'(bus.out_valid), 32'd1);
        check("mulnop_result", bus.result, 32'd0);
        check("mulnop_flags", 32'(bus.flags), 32'b0100);
        consume();

        send(OP_ADD, COND_AL, 1'b1, 3'd0, 5'd0, 32'h8000_0000, 32'd0, 16'h0);
        check("prerst_flags", 32'(bus.flags), 32'b1000);
        rst = 1'b1;
        @(negedge clk);
        check("holdrst_valid", 32'(bus.out_valid), 32'd0);
        check("holdrst_flags", 32'(bus.flags), 32'h0);
        check("holdrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("holdrst_ready_after", 32'(bus.in_ready), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (power of two, 8..64).
REQ-002 SHALL have derived parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  operation accepted when in_valid && in_ready.
REQ-007 opcode  in  4  0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 MOVI, 7 MOV, 11 CMP, 13 LDR, 15 NOP, other STR.
REQ-008 cond  in  4  0 AL, 1 EQ, 2 GT, 3 LT, 4 GE, 5 LE, 6 HI, 7 LO, 8 HS, 9..15 never.
REQ-009 s  in  1  flag-update enable.
REQ-010 sr_cont  in  3  in2 pre-shift: 1 LSR, 2 LSL, 3 ROR, other none.
REQ-011 sr_bit  in  SHW  shift/rotate amount.
REQ-012 in1, in2  in  WIDTH each  operands.
REQ-013 imm  in  16  MOVI immediate.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  result consumed when out_valid && out_ready.
REQ-016 result  out  WIDTH  registered result.
REQ-017 cond_met  out  1  registered condition outcome for the result.
REQ-018 flags  out  4  registered {N,Z,C,V}.

Function
REQ-019 Condition SHALL be evaluated at accept against the current flags register: EQ Z; GT !Z&&N==V; LT N!=V; GE N==V; LE Z||N!=V; HI C&&!Z; LO !C; HS C.
REQ-020 The shifted operand sh2 SHALL derive from in2 per sr_cont/sr_bit; it feeds ADD, SUB, MUL, OR, AND, XOR and CMP.
REQ-021 Results: ADD in1+sh2; SUB/CMP in1-sh2 (CMP result 0); MUL low WIDTH bits of in1*sh2; logic bitwise; MOVI zero-extended imm; MOV/LDR/STR in1; NOP 0.
REQ-022 Flags: N=msb, Z=(value==0); ADD C=carry-out; SUB/CMP C=no-borrow; V=signed overflow; logic and MUL clear C and V.
REQ-023 Flags SHALL update only if cond met and (CMP, or s=1 with opcode 0..5); CMP flags derive from in1-sh2.
REQ-024 If cond not met, result=0, cond_met=0, flags unchanged; out_valid still asserts.
REQ-025 FSM states IDLE, MUL, HOLD; IDLE->MUL on accepted MUL with cond met; IDLE->HOLD on other accept; MUL->HOLD after WIDTH iterations; HOLD->IDLE when out_ready.
REQ-026 in_ready SHALL be 1 only in IDLE with rst low.
REQ-027 Non-MUL latency: out_valid asserts 1 cycle after accept; MUL latency: WIDTH+1 cycles.
REQ-028 result, cond_met, out_valid SHALL hold stable in HOLD until out_ready; no input accepted meanwhile.
REQ-029 Flags of an operation SHALL be visible in the cycle out_valid first asserts.

Reset
REQ-030 On rst: state IDLE, out_valid 0, result 0, cond_met 0, flags 0000; in-flight MUL discarded.
REQ-031 rst asserted in any state SHALL take effect on the next edge with priority over all handshakes.

Configuration
REQ-032 Macro SEQ_ALU_MUL_EN defined: iterative MUL as specified.
REQ-033 Macro SEQ_ALU_MUL_EN undefined: MUL treated as NOP (result 0, 1-cycle latency, no flag update), MUL state absent.

Structure
REQ-034 Package seq_alu_pkg SHALL hold opcode and cond localparams, FSM state typedef, and flag bit indices N=3, Z=2, C=1, V=0.
REQ-035 Sub-module seq_alu_mul SHALL implement the shift-add multiplier (start, done, WIDTH-bit operands/product).

Verification
REQ-036 ADD in1=0x7FFFFFFF, in2=1, s=1 -> result 0x80000000, flags N1 Z0 C0 V1, out_valid 1 cycle after accept.
REQ-037 CMP 5,5 then SUB cond EQ 10,3 -> 7, cond_met 1; then SUB cond GT -> result 0, cond_met 0, flags unchanged (Z=1, C=1).
REQ-038 MUL 0xFFFF*0x10001 -> 0xFFFFFFFF, out_valid exactly 33 cycles after accept, in_ready 0 throughout.
REQ-039 OR in1=0, in2=0x80000001, sr_cont=3, sr_bit=1 -> 0xC0000000.
REQ-040 out_ready held 0 for 3 cycles -> result stable, in_ready 0; accepted on 4th cycle, in_ready 1 next cycle.
REQ-041 rst at cycle 10 of MUL -> next cycle out_valid 0, flags 0000, in_ready 1 after rst deasserts.
